// File: rtl/router_alloc_pkg.sv
// Shared types and helpers for the NoC router output-port switch allocator.
package router_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_LOCKED
  } alloc_state_e;

  // Modulo increment that works for any n, power of two or not.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/router_output_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after ptr, scanning cyclically. Shared with the local-port shim.
module rr_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant
);

  logic                 found;
  int                   slot;
  logic [PTR_WIDTH-1:0] idx;

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    slot  = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      idx = PTR_WIDTH'(slot);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_allocator.sv
// Per-output-port switch allocator: round-robin arbitration, wormhole lock and
// downstream credit tracking. Define ROUTER_ALLOC_STATS_EN for packet/stall counters.
module router_output_allocator
  import router_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int PORT_WIDTH        = $clog2(NUM_INPUTS)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic [NUM_INPUTS-1:0]   sel_out,
  output logic                    send_out,
  output logic                    tail_out,
  output logic                    locked,
  output logic [PORT_WIDTH-1:0]   owner,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_err
`ifdef ROUTER_ALLOC_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_stalls
`endif
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

  alloc_state_e          state, state_next;
  logic [PORT_WIDTH-1:0] ptr, ptr_next, owner_next, win_idx;
  logic [NUM_INPUTS-1:0] elig, arb_grant;
  logic                  credit_ok, any_grant, grant_tail;

  assign elig      = req & ~turn_disable;
  assign credit_ok = (credit_count != '0);
  assign locked    = (state == ALLOC_LOCKED);

  rr_arbiter #(
    .NUM_REQ   (NUM_INPUTS),
    .PTR_WIDTH (PORT_WIDTH)
  ) u_arb (
    .req   (elig),
    .ptr   (ptr),
    .grant (arb_grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (arb_grant[i]) win_idx = PORT_WIDTH'(i);
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    grant      = '0;
    case (state)
      ALLOC_IDLE: begin
        if (credit_ok && |arb_grant) begin
          grant = arb_grant;
          if (req_is_tail[win_idx]) begin
            ptr_next = PORT_WIDTH'(next_ptr(int'(win_idx), NUM_INPUTS));
          end else begin
            state_next = ALLOC_LOCKED;
            owner_next = win_idx;
          end
        end
      end
      ALLOC_LOCKED: begin
        // Only the owner may advance; turn_disable no longer matters mid-packet.
        if (credit_ok && req[owner]) begin
          grant[owner] = 1'b1;
          if (req_is_tail[owner]) begin
            state_next = ALLOC_IDLE;
            owner_next = '0;
            ptr_next   = PORT_WIDTH'(next_ptr(int'(owner), NUM_INPUTS));
          end
        end
      end
      default: state_next = ALLOC_IDLE;
    endcase
  end

  assign any_grant  = |grant;
  assign grant_tail = |(grant & req_is_tail);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state        <= ALLOC_IDLE;
      ptr          <= '0;
      owner        <= '0;
      credit_count <= CREDIT_MAX;
      credit_err   <= 1'b0;
      sel_out      <= '0;
      send_out     <= 1'b0;
      tail_out     <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      owner    <= owner_next;
      sel_out  <= grant;
      send_out <= any_grant;
      tail_out <= grant_tail;
      case ({any_grant, credit_in})
        2'b10: credit_count <= credit_count - CREDIT_ONE;
        2'b01: begin
          if (credit_count == CREDIT_MAX) credit_err <= 1'b1;
          else                            credit_count <= credit_count + CREDIT_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef ROUTER_ALLOC_STATS_EN
  logic stall;

  assign stall = !credit_ok && (locked ? req[owner] : |elig);

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      stat_pkts   <= '0;
      stat_stalls <= '0;
    end else begin
      if (grant_tail) stat_pkts   <= stat_pkts + 32'd1;
      if (stall)      stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule
